// File: rtl/m_ext_iter_unit.sv
// Iterative RV32M unit: one bit per cycle shift-add multiply and restoring divide.
// Optional macro M_EARLY_OUT_EN lets trivial operations skip the iteration phase.
module m_ext_iter_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startE,
  input  logic [4:0]      alu_opE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  output logic            mul_use,
  output logic            flagM,
  output logic [XLEN-1:0] result_m
);

  localparam int CW = $clog2(XLEN);

  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_DIVU   = 5'b10000;
  localparam logic [4:0] OP_REM    = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [4:0]        op;
  logic              a_neg, b_neg, div_zero;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;

  logic              is_m_op, accept, op_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic              is_div, done_entry;
  logic [XLEN:0]     mul_sum, div_shift, div_sub;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod_signed;
  logic [XLEN-1:0]   quo, rem, quo_res, rem_res, final_res;

`ifdef M_EARLY_OUT_EN
  logic              early, early_in;
  logic [XLEN-1:0]   early_res, early_res_in;
  logic              ovf_in;
`endif

  // Request decode and operand magnitudes, sampled on the accepting edge
  always_comb begin
    is_m_op   = (alu_opE >= OP_MUL) && (alu_opE <= OP_REMU);
    accept    = (state == IDLE) && startE && is_m_op;
    op_div_in = (alu_opE >= OP_DIV);
    a_sgn_in  = (alu_opE == OP_MUL) || (alu_opE == OP_MULH) || (alu_opE == OP_MULHSU) ||
                (alu_opE == OP_DIV) || (alu_opE == OP_REM);
    b_sgn_in  = (alu_opE == OP_MUL) || (alu_opE == OP_MULH) ||
                (alu_opE == OP_DIV) || (alu_opE == OP_REM);
    a_neg_in  = a_sgn_in && SrcAE[XLEN-1];
    b_neg_in  = b_sgn_in && SrcBE[XLEN-1];
    a_mag_in  = a_neg_in ? -SrcAE : SrcAE;
    b_mag_in  = b_neg_in ? -SrcBE : SrcBE;
  end

`ifdef M_EARLY_OUT_EN
  always_comb begin
    ovf_in       = ((alu_opE == OP_DIV) || (alu_opE == OP_REM)) &&
                   (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (SrcBE == '1);
    early_in     = 1'b0;
    early_res_in = '0;
    if (op_div_in) begin
      if (SrcBE == '0) begin
        early_in     = 1'b1;
        early_res_in = ((alu_opE == OP_DIV) || (alu_opE == OP_DIVU)) ? '1 : SrcAE;
      end else if (ovf_in) begin
        early_in     = 1'b1;
        early_res_in = (alu_opE == OP_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
      end
    end else if ((SrcAE == '0) || (SrcBE == '0)) begin
      early_in = 1'b1;
    end
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration step; the divider borrow bit doubles as the compare result
  always_comb begin
    is_div     = (op >= OP_DIV);
    done_entry = (state == BUSY) && (cnt == '0);
    mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next   = {mul_sum, acc[XLEN-1:1]};
    div_shift  = acc[2*XLEN-1:XLEN-1];
    div_sub    = div_shift - {1'b0, opnd};
    div_ge     = ~div_sub[XLEN];
    div_rem    = div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0];
    div_next   = {div_rem, acc[XLEN-2:0], div_ge};
    acc_next   = is_div ? div_next : mul_next;
  end

  always_comb begin
    prod_signed = (a_neg ^ b_neg) ? -mul_next : mul_next;
    quo         = div_next[XLEN-1:0];
    rem         = div_next[2*XLEN-1:XLEN];
    quo_res     = div_zero ? '1 : ((a_neg ^ b_neg) ? -quo : quo);
    rem_res     = a_neg ? -rem : rem;
    case (op)
      OP_MUL:                       final_res = prod_signed[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_signed[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quo_res;
      OP_REM, OP_REMU:              final_res = rem_res;
      default:                      final_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= '0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      div_zero  <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      result_m  <= '0;
`ifdef M_EARLY_OUT_EN
      early     <= 1'b0;
      early_res <= '0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        op       <= alu_opE;
        a_neg    <= a_neg_in;
        b_neg    <= b_neg_in;
        div_zero <= (SrcBE == '0);
        if (op_div_in) begin
          opnd <= b_mag_in;
          acc  <= {{XLEN{1'b0}}, a_mag_in};
        end else begin
          opnd <= a_mag_in;
          acc  <= {{XLEN{1'b0}}, b_mag_in};
        end
`ifdef M_EARLY_OUT_EN
        early     <= early_in;
        early_res <= early_res_in;
        cnt       <= early_in ? '0 : CW'(XLEN-1);
`else
        cnt       <= CW'(XLEN-1);
`endif
      end else if (state == BUSY) begin
        acc <= acc_next;
        cnt <= cnt - CW'(1);
      end
      if (done_entry) begin
`ifdef M_EARLY_OUT_EN
        result_m <= early ? early_res : final_res;
`else
        result_m <= final_res;
`endif
      end
    end
  end

  assign mul_use = (state == BUSY);
  assign flagM   = (state == DONE);

endmodule

// File: doc/m_ext_iter_unit.md
Name: m_ext_iter_unit

Overview:
- Iterative RV32M execute unit: one bit per cycle shift-add multiply and restoring divide.
- Produces `result_m`, `flagM` and `mul_use`, which the execute-stage ALU consumes.
- The ALU selects `result_m` when `flagM`=1 and suppresses its own result while `mul_use`=1.
- Sits in the E stage beside the ALU; the hazard unit stalls the pipeline on `mul_use`.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk      input   1     rising-edge clock
- rst      input   1     synchronous reset, active-low
- startE   input   1     E-stage request strobe; qualified by an M opcode on `alu_opE`
- alu_opE  input   5     op: MUL 01011, MULH 01100, MULHSU 01101, MULHU 01110, DIV 01111, DIVU 10000, REM 10001, REMU 10010
- SrcAE    input   XLEN  rs1 operand (multiplicand / dividend)
- SrcBE    input   XLEN  rs2 operand (multiplier / divisor)
- mul_use  output  1     unit busy; stalls the pipeline and blocks the ALU result
- flagM    output  1     one-cycle pulse: `result_m` valid this cycle
- result_m output  XLEN  final result, registered, held until the next completion

Behaviour:
- Reset: rst=0 at a clock edge forces state IDLE, `mul_use`=0, `flagM`=0, `result_m`=0, and clears all internal registers. This applies mid-operation: the operation is abandoned and no `flagM` is issued.
- States:
  - IDLE -> BUSY when startE=1 and `alu_opE` is in 01011..10010. Opcode, sign flags and operand magnitudes are latched on that edge.
  - startE with a non-M opcode is ignored.
  - BUSY: iteration counter counts XLEN-1 down to 0, one step per cycle. Counter 0 -> DONE.
  - DONE: `flagM`=1 for exactly one cycle and `result_m` is updated on entry. Next state is IDLE; a new startE in DONE is not accepted.
- Latency: start accepted at edge 0, so `mul_use`=1 from cycle 1 through cycle XLEN. DONE is in cycle XLEN+1 (33 cycles for XLEN=32), with `mul_use`=0 and `flagM`=1.
- startE while BUSY/DONE: ignored; latched operands are unaffected.
- Multiply:
  - Operands are converted to magnitudes per signedness: MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
  - 2*XLEN product register, shift-add each cycle.
  - The final product is negated when the sign flags differ.
  - MUL returns bits [XLEN-1:0]; MULH/MULHSU/MULHU return bits [2*XLEN-1:XLEN].
- Divide:
  - Restoring algorithm on magnitudes (signed for DIV/REM, unsigned for DIVU/REMU).
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Boundary cases (the full iteration count still runs):
  - Divisor 0: DIV/DIVU give all-ones (0xFFFFFFFF); REM/REMU give the dividend.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
  - Negation of 0x80000000 magnitude is handled in XLEN+1 bits; no wrong sign.
- `result_m` holds its last value while IDLE/BUSY.

Optional Feature:
- Macro M_EARLY_OUT_EN.
- Defined: on accept, divisor==0, signed overflow, or either multiply operand==0 skips BUSY and goes straight to DONE. `mul_use`=1 for cycle 1 only and `flagM`=1 in cycle 2, with results as specified above.
- Undefined: every operation takes the full XLEN+1 cycles; no early-out logic is synthesized.

Test Plan:
- MUL, A=7, B=-3 (0xFFFFFFFD) -> `mul_use` high cycles 1..32; `flagM` pulse cycle 33; `result_m`=0xFFFFFFEB.
- MULH A=0x80000000, B=0x80000000 -> 0x40000000; MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU A=-1, B=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV A=-7, B=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU A=100, B=7 -> 14; REMU -> 2.
- DIV/REM with B=0, A=0x1234 -> 0xFFFFFFFF / 0x1234. DIV A=0x80000000, B=-1 -> 0x80000000; REM -> 0. With M_EARLY_OUT_EN: `flagM` in cycle 2.
- rst=0 at cycle 10 of a DIV -> next cycle `mul_use`=0, `flagM` never pulses, `result_m`=0. A new MUL 3x5 then completes normally with 15.
- startE re-asserted at cycle 5 with different operands, plus startE with ADD (00000) while IDLE -> first op result unchanged; ADD produces no `mul_use`/`flagM` activity.
